uart_gonderim_fifo: RTL and testbench

//  Byte FIFO between the bus-side UART register write path and the UART transmitter.

---
 rtl/uart_gonderim_fifo_if.sv | 49 ++++
 rtl/uart_gonderim_fifo.sv | 94 +++++++++
 tb/tb_uart_gonderim_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_gonderim_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_gonderim_fifo_if
// Purpose  : Handshake bundle between the bus-side write path, the FIFO
//            and the UART transmitter. Optional threshold signals exist
//            only when UART_GONDERIM_FIFO_ESIK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_gonderim_fifo_if #(
  parameter int DERINLIK      = 16,
  parameter int VERI_GENISLIK = 8
);
  localparam int AW = $clog2(DERINLIK);

  logic                     yaz_gecerli_i;
  logic [VERI_GENISLIK-1:0] yaz_veri_i;
  logic                     yaz_hazir_o;
  logic                     temizle_i;
  logic                     veri_gecerli_o;
  logic [VERI_GENISLIK-1:0] veri_o;
  logic                     tuket_i;
  logic [AW:0]              doluluk_o;
  logic                     tasma_o;
`ifdef UART_GONDERIM_FIFO_ESIK_EN
  logic [AW:0]              esik_i;
  logic                     kesme_o;
`endif

  // Producer/consumer side (bus writer, transmitter, testbench)
  modport master (
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    output esik_i,
    input  kesme_o,
`endif
    output yaz_gecerli_i, yaz_veri_i, temizle_i, tuket_i,
    input  yaz_hazir_o, veri_gecerli_o, veri_o, doluluk_o, tasma_o
  );

  // FIFO side
  modport slave (
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    input  esik_i,
    output kesme_o,
`endif
    input  yaz_gecerli_i, yaz_veri_i, temizle_i, tuket_i,
    output yaz_hazir_o, veri_gecerli_o, veri_o, doluluk_o, tasma_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_gonderim_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_gonderim_fifo
// Purpose  : First-word-fall-through byte FIFO feeding the UART transmitter.
//            Sticky overflow flag, synchronous flush.
//            Define UART_GONDERIM_FIFO_ESIK_EN to add the low-watermark
//            threshold input esik_i and registered flag kesme_o.
// Revision : 1.0 - initial release
// ============================================================================
module uart_gonderim_fifo #(
  parameter int DERINLIK      = 16,
  parameter int VERI_GENISLIK = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  uart_gonderim_fifo_if.slave   bus
);
  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW:0] PTR_BIR = (AW+1)'(1);

  logic [VERI_GENISLIK-1:0] mem [DERINLIK];
  logic [AW:0] yaz_ptr;
  logic [AW:0] oku_ptr;
  logic [AW:0] yaz_ptr_next;
  logic [AW:0] oku_ptr_next;
  logic        tasma;
  logic        bos;
  logic        dolu;
  logic        yaz_kabul;
  logic        oku_kabul;

  assign bos       = (yaz_ptr == oku_ptr);
  assign dolu      = (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]) && (yaz_ptr[AW] != oku_ptr[AW]);
  assign yaz_kabul = bus.yaz_gecerli_i && !dolu;
  assign oku_kabul = bus.tuket_i && !bos;

  assign bus.yaz_hazir_o    = !dolu;
  assign bus.veri_gecerli_o = !bos;
  assign bus.veri_o         = bos ? '0 : mem[oku_ptr[AW-1:0]];
  assign bus.doluluk_o      = yaz_ptr - oku_ptr;
  assign bus.tasma_o        = tasma;

  // Next pointer values: flush zeroes both, otherwise accepted write/pop advance
  always_comb begin
    yaz_ptr_next = yaz_ptr;
    oku_ptr_next = oku_ptr;
    if (bus.temizle_i) begin
      yaz_ptr_next = '0;
      oku_ptr_next = '0;
    end else begin
      if (yaz_kabul) yaz_ptr_next = yaz_ptr + PTR_BIR;
      if (oku_kabul) oku_ptr_next = oku_ptr + PTR_BIR;
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      yaz_ptr <= yaz_ptr_next;
      oku_ptr <= oku_ptr_next;
    end
  end

  // Sticky overflow: a write into a full FIFO with no same-cycle pop to
  // relieve it; a full FIFO being drained in that cycle only rejects the byte
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.temizle_i) tasma <= 1'b0;
    else if (bus.yaz_gecerli_i && dolu && !bus.tuket_i) tasma <= 1'b1;
  end

  // Storage write; contents are never reset, only the pointers are
  always_ff @(posedge clk_i) begin
    if (!rst_i && !bus.temizle_i && yaz_kabul) mem[yaz_ptr[AW-1:0]] <= bus.yaz_veri_i;
  end

`ifdef UART_GONDERIM_FIFO_ESIK_EN
  logic [AW:0] doluluk_next;
  logic        kesme;

  assign doluluk_next = yaz_ptr_next - oku_ptr_next;
  assign bus.kesme_o  = kesme;

  // Low-watermark flag tracks the occupancy that the pointers are about to hold
  always_ff @(posedge clk_i) begin
    if (rst_i) kesme <= 1'b0;
    else       kesme <= (doluluk_next <= bus.esik_i);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_gonderim_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_gonderim_fifo
// Purpose  : Directed self-checking bench for uart_gonderim_fifo.
//            Threshold scenario is built when UART_GONDERIM_FIFO_ESIK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_gonderim_fifo;
  localparam int DERINLIK = 16;
  localparam int VG       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  uart_gonderim_fifo_if #(.DERINLIK(DERINLIK), .VERI_GENISLIK(VG)) bus ();

  uart_gonderim_fifo #(.DERINLIK(DERINLIK), .VERI_GENISLIK(VG)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.yaz_gecerli_i = 1'b0;
    bus.yaz_veri_i    = '0;
    bus.temizle_i     = 1'b0;
    bus.tuket_i       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.yaz_gecerli_i = 1'b1;
    bus.yaz_veri_i    = d;
    step();
    bus.yaz_gecerli_i = 1'b0;
  endtask

  task automatic pop();
    bus.tuket_i = 1'b1;
    step();
    bus.tuket_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.veri_gecerli_o); end
    checks++; if (bus.yaz_hazir_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.yaz_hazir_o); end
    checks++; if (bus.doluluk_o !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.doluluk_o); end
    checks++; if (bus.veri_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.veri_o); end
    checks++; if (bus.tasma_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.tasma_o); end
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    checks++; if (bus.kesme_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.kesme_o); end
`endif
  endtask

  task automatic test_single();
    do_reset();
    wr(8'hA5);
    checks++; if (bus.veri_gecerli_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.veri_gecerli_o); end
    checks++; if (bus.veri_o !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.veri_o); end
    checks++; if (bus.doluluk_o !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.doluluk_o); end
    pop();
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", bus.veri_gecerli_o); end
    checks++; if (bus.veri_o !== 8'h00) begin failures++; $display("FAIL single_pop_data got=%h exp=00", bus.veri_o); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) wr(8'(i));
    checks++; if (bus.yaz_hazir_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.yaz_hazir_o); end
    checks++; if (bus.doluluk_o !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", bus.doluluk_o); end
    checks++; if (bus.tasma_o !== 1'b0) begin failures++; $display("FAIL full_ovf_early got=%b exp=0", bus.tasma_o); end
    wr(8'hFF);
    checks++; if (bus.tasma_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.tasma_o); end
    checks++; if (bus.doluluk_o !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", bus.doluluk_o); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.veri_o !== 8'(i)) begin failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, bus.veri_o, 8'(i)); end
      pop();
    end
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.veri_gecerli_o); end
    checks++; if (bus.tasma_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.tasma_o); end
    pop();
    checks++; if (bus.doluluk_o !== 5'd0) begin failures++; $display("FAIL pop_empty_count got=%0d exp=0", bus.doluluk_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin wr(8'(100 + i)); exp_q.push_back(8'(100 + i)); end
    for (int c = 0; c < 40; c++) begin
      e = exp_q.pop_front();
      checks++; if (bus.veri_o !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", c, bus.veri_o, e); end
      checks++; if (bus.doluluk_o !== 5'd5) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=5", c, bus.doluluk_o); end
      bus.yaz_gecerli_i = 1'b1;
      bus.yaz_veri_i    = 8'(c);
      bus.tuket_i       = 1'b1;
      exp_q.push_back(8'(c));
      step();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      checks++; if (bus.veri_o !== e) begin failures++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, bus.veri_o, e); end
      pop();
    end
    // write and pop together on an empty FIFO: write lands, pop ignored
    bus.yaz_gecerli_i = 1'b1; bus.yaz_veri_i = 8'h3C; bus.tuket_i = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.doluluk_o !== 5'd1) begin failures++; $display("FAIL empty_wrpop_count got=%0d exp=1", bus.doluluk_o); end
    checks++; if (bus.veri_o !== 8'h3C) begin failures++; $display("FAIL empty_wrpop_data got=%h exp=3c", bus.veri_o); end
  endtask

  task automatic test_full_write_pop();
    do_reset();
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    bus.yaz_gecerli_i = 1'b1; bus.yaz_veri_i = 8'h77; bus.tuket_i = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.doluluk_o !== 5'd15) begin failures++; $display("FAIL fullwp_count got=%0d exp=15", bus.doluluk_o); end
    checks++; if (bus.tasma_o !== 1'b0) begin failures++; $display("FAIL fullwp_ovf got=%b exp=0", bus.tasma_o); end
    checks++; if (bus.yaz_hazir_o !== 1'b1) begin failures++; $display("FAIL fullwp_ready got=%b exp=1", bus.yaz_hazir_o); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (bus.veri_o !== 8'(8'h10 + i)) begin failures++; $display("FAIL fullwp_drain[%0d] got=%h exp=%h", i, bus.veri_o, 8'(8'h10 + i)); end
      pop();
    end
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL fullwp_empty got=%b exp=0", bus.veri_gecerli_o); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'hEE);
    for (int i = 0; i < 8; i++) pop();
    checks++; if (bus.doluluk_o !== 5'd8 || bus.tasma_o !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0d/%b exp=8/1", bus.doluluk_o, bus.tasma_o); end
    bus.temizle_i = 1'b1; bus.yaz_gecerli_i = 1'b1; bus.yaz_veri_i = 8'h55;
    step();
    idle_inputs();
    checks++; if (bus.doluluk_o !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", bus.doluluk_o); end
    checks++; if (bus.tasma_o !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", bus.tasma_o); end
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.veri_gecerli_o); end
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    checks++; if (bus.kesme_o !== 1'b1) begin failures++; $display("FAIL flush_irq got=%b exp=1", bus.kesme_o); end
`endif
    for (int i = 0; i < 3; i++) wr(8'(8'h40 + i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.doluluk_o !== 5'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", bus.doluluk_o); end
    checks++; if (bus.veri_gecerli_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", bus.veri_gecerli_o); end
    checks++; if (bus.veri_o !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", bus.veri_o); end
  endtask

`ifdef UART_GONDERIM_FIFO_ESIK_EN
  task automatic test_esik();
    bus.esik_i = 5'd2;
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'(i));
    step();
    checks++; if (bus.kesme_o !== 1'b0) begin failures++; $display("FAIL esik_4 got=%b exp=0", bus.kesme_o); end
    pop();
    checks++; if (bus.kesme_o !== 1'b0) begin failures++; $display("FAIL esik_3 got=%b exp=0", bus.kesme_o); end
    pop();
    checks++; if (bus.doluluk_o !== 5'd2) begin failures++; $display("FAIL esik_count got=%0d exp=2", bus.doluluk_o); end
    step();
    checks++; if (bus.kesme_o !== 1'b1) begin failures++; $display("FAIL esik_2 got=%b exp=1", bus.kesme_o); end
  endtask
`endif

  initial begin
    idle_inputs();
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    bus.esik_i = '0;
`endif
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_full_write_pop();
    test_flush_reset();
`ifdef UART_GONDERIM_FIFO_ESIK_EN
    test_esik();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
